mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit and its controller for the five-stage pipelined MIPS core.
- Sits beside the execute-stage ALU:
  - accepts one MDU operation per start pulse;
  - holds HI/LO;
  - runs a busy counter;
  - raises a stall request so the decode stage never issues an MDU instruction (MULT/DIV/MFHI/MFLO/MTHI/MTLO) while an operation is in flight.

---
 rtl/mdu_sequencer.sv | 127 ++++++++++++
 tb/tb_mdu_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide unit for the MIPS execute stage: holds HI/LO,
// runs a busy counter per operation and requests decode stalls while busy.
module mdu_sequencer #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        o_dbg_state
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_busy;
  logic [31:0]     r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic            w_load_pend, w_commit, w_mthi, w_mtlo;

  logic            w_is_md, w_is_mul, w_div_signed, w_neg_a, w_neg_b, w_div0;
  logic [31:0]     w_abs_a, w_abs_b, w_uq, w_ur, w_q, w_r;
  logic [63:0]     w_mul_s, w_mul_u, w_result;

  assign w_is_md      = (md_op >= 3'd1) && (md_op <= 3'd4);
  assign w_is_mul     = (md_op == 3'd1) || (md_op == 3'd2);
  assign w_div_signed = (md_op == 3'd3);

  assign w_mul_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign w_mul_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  assign w_neg_a = w_div_signed & rs_val[31];
  assign w_neg_b = w_div_signed & rt_val[31];
  assign w_abs_a = w_neg_a ? (32'd0 - rs_val) : rs_val;
  assign w_abs_b = w_neg_b ? (32'd0 - rt_val) : rt_val;
  assign w_div0  = (rt_val == 32'd0);
  assign w_uq    = w_div0 ? 32'd0 : (w_abs_a / w_abs_b);
  assign w_ur    = w_div0 ? 32'd0 : (w_abs_a % w_abs_b);
  assign w_q     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
  assign w_r     = w_neg_a ? (32'd0 - w_ur) : w_ur;

  always_comb begin
    w_result = {r_hi, r_lo};
    case (md_op)
      3'd1:       w_result = w_mul_s;
      3'd2:       w_result = w_mul_u;
      3'd3, 3'd4: w_result = w_div0 ? {r_hi, r_lo} : {w_r, w_q};
      default:    w_result = {r_hi, r_lo};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_pend = 1'b0;
    w_commit    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_is_md) begin
          w_load_pend = 1'b1;
          w_cnt_nxt   = w_is_mul ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);
          w_state_nxt = S_RUN;
        end else if (start && md_op == 3'd5) begin
          w_mthi = 1'b1;
        end else if (start && md_op == 3'd6) begin
          w_mtlo = 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      if (w_load_pend) begin
        r_pend_hi <= w_result[63:32];
        r_pend_lo <= w_result[31:0];
      end
      if (w_commit) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_mthi) r_hi <= rs_val;
      if (w_mtlo) r_lo <= rs_val;
    end
  end

  assign busy        = r_busy;
  assign md_stall    = d_md_use & (r_busy | (start & w_is_md));
  assign hi_out      = r_hi;
  assign lo_out      = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table of MDU operations with a
// result scoreboard, plus directed sequences for MTHI/MTLO, ignored starts and reset.
module tb_mdu_sequencer;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          lat;
    bit          use_d;
  } vec_t;

  logic        clk, reset, start, d_md_use;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, md_stall, dbg_state;
  logic [31:0] hi_out, lo_out;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;
  int          n_tests, n_fail;
  vec_t        vecs[$];

  mdu_sequencer #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .d_md_use(d_md_use),
    .busy(busy), .md_stall(md_stall), .hi_out(hi_out), .lo_out(lo_out),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    res = 64'd0;
    case (op)
      3'd1: res = longint'($signed(a)) * longint'($signed(b));
      3'd2: res = {32'd0, a} * {32'd0, b};
      3'd3: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa / sb; r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd4: begin
        sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
        q = sa / sb; r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // driver: one MDU op, scoreboard push at start, pop when busy falls
  task automatic run_vec(input vec_t v);
    logic [63:0] e;
    int n;
    start = 1'b1; md_op = v.op; rs_val = v.rs; rt_val = v.rt; d_md_use = v.use_d;
    exp_q.push_back({v.ehi, v.elo});
    #1;
    chk("stall_at_start", md_stall, v.use_d);
    tick();
    start = 1'b0; md_op = 3'd0; rs_val = $urandom; rt_val = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      chk("stall_busy", md_stall, v.use_d);
      chk("hold_hilo", {hi_out, lo_out}, {m_hi, m_lo});
      n++;
      tick();
    end
    chk("latency", n, v.lat);
    chk("stall_after", md_stall, 1'b0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("result", {hi_out, lo_out}, e);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
    d_md_use = 1'b0;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    vec_t v;
    logic [63:0] e;
    int n;
    n_tests = 0; n_fail = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; d_md_use = 1'b0;

    vecs.push_back('{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b1});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, 1'b0});
    vecs.push_back('{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0});
    vecs.push_back('{3'd4, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b1});
    vecs.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0});
    vecs.push_back('{3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10, 1'b0});
    vecs.push_back('{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 1'b1});
    for (int i = 0; i < 6; i++) begin
      v.op = 3'($urandom_range(1, 4));
      v.rs = $urandom;
      v.rt = (v.op >= 3'd3 && $urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 50)) : $urandom;
      if (v.rt == 32'd0) v.rt = 32'd1;
      e = model(v.op, v.rs, v.rt);
      v.ehi = e[63:32]; v.elo = e[31:0];
      v.lat = (v.op <= 3'd2) ? 5 : 10;
      v.use_d = 1'($urandom_range(0, 1));
      vecs.push_back(v);
    end

    // reset state, during and after reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_hilo", {hi_out, lo_out}, 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_stall", md_stall, 1'b0);
    chk("idle_hilo", {hi_out, lo_out}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // MTHI then MTLO on consecutive cycles, with an MDU-class D-stage op
    start = 1'b1; md_op = 3'd5; rs_val = 32'h12345678; d_md_use = 1'b1;
    #1;
    chk("mthi_stall", md_stall, 1'b0);
    tick();
    chk("mthi_hi", hi_out, 32'h12345678);
    chk("mthi_lo", lo_out, m_lo);
    chk("mthi_busy", busy, 1'b0);
    md_op = 3'd6; rs_val = 32'h9ABCDEF0;
    tick();
    chk("mtlo_lo", lo_out, 32'h9ABCDEF0);
    chk("mtlo_hi", hi_out, 32'h12345678);
    chk("mtlo_busy", busy, 1'b0);
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

    // md_op 0 and 7 are no-ops
    md_op = 3'd0; rs_val = 32'h0BADF00D; rt_val = 32'h5;
    tick();
    md_op = 3'd7;
    #1;
    chk("nop7_stall", md_stall, 1'b0);
    tick();
    start = 1'b0; d_md_use = 1'b0;
    chk("nop_busy", busy, 1'b0);
    chk("nop_hilo", {hi_out, lo_out}, {m_hi, m_lo});

    // starts during a DIV run (MULT, then MTHI) are ignored
    start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
    exp_q.push_back({32'd2, 32'd14});
    tick();
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      if (n < 3) begin
        start = 1'b1; md_op = (n < 2) ? 3'd1 : 3'd5; rs_val = 32'hDEAD0000 + 32'(n); rt_val = 32'd5;
      end else begin
        start = 1'b0; md_op = 3'd0;
      end
      chk("run_hold", {hi_out, lo_out}, {m_hi, m_lo});
      n++;
      tick();
    end
    start = 1'b0; md_op = 3'd0;
    chk("run_ign_lat", n, 10);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("run_ign_res", {hi_out, lo_out}, e);
      m_hi = e[63:32]; m_lo = e[31:0];
    end
    tick();
    chk("run_ign_nobusy", busy, 1'b0);

    // asynchronous reset in the third busy cycle of a DIV
    start = 1'b1; md_op = 3'd3; rs_val = 32'hFFFFFFF9; rt_val = 32'd2; d_md_use = 1'b1;
    tick();
    start = 1'b0; md_op = 3'd0;
    tick();
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_stall", md_stall, 1'b0);
    chk("mid_rst_hilo", {hi_out, lo_out}, 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_hilo", {hi_out, lo_out}, 64'd0);
    end
    d_md_use = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
